// File: rtl/stop_watch_ctrl.sv
// rtl/stop_watch_ctrl.sv - stopwatch front-panel controller: button sync/debounce, run/stop/lap FSM, lap latch
module stop_watch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [6:0]  min_in,
  input  logic [6:0]  sec_in,
  input  logic [14:0] msec_in,
  output logic        enable,
  output logic        zero,
  output logic        lap_valid,
  output logic [6:0]  lap_min,
  output logic [6:0]  lap_sec,
  output logic [14:0] lap_msec,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]       s1, s2, db, db_d, press;
  logic [CNT_W-1:0] cnt [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= {btn_lr, btn_ss};
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == CNT_MAX) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db & ~db_d;

  state_t state_q, state_n;
  logic   zero_n, lap_valid_n, lap_load, lap_clear;

  // Start/stop has priority; a coincident lap/reset press is dropped.
  always_comb begin
    state_n     = state_q;
    zero_n      = 1'b0;
    lap_valid_n = lap_valid;
    lap_load    = 1'b0;
    lap_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press[0])      state_n = RUN;
        else if (press[1]) zero_n  = 1'b1;
      end
      RUN: begin
        if (press[0]) begin
          state_n = STOP;
        end else if (press[1]) begin
          state_n     = LAP;
          lap_load    = 1'b1;
          lap_valid_n = 1'b1;
        end
      end
      LAP: begin
        if (press[0]) begin
          state_n     = STOP;
          lap_valid_n = 1'b0;
        end else if (press[1]) begin
          state_n     = RUN;
          lap_valid_n = 1'b0;
        end
      end
      STOP: begin
        if (press[0]) begin
          state_n = RUN;
        end else if (press[1]) begin
          state_n   = IDLE;
          zero_n    = 1'b1;
          lap_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      zero      <= 1'b0;
      lap_valid <= 1'b0;
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_msec  <= '0;
    end else begin
      state_q   <= state_n;
      zero      <= zero_n;
      lap_valid <= lap_valid_n;
      if (lap_clear) begin
        lap_min  <= '0;
        lap_sec  <= '0;
        lap_msec <= '0;
      end else if (lap_load) begin
        lap_min  <= min_in;
        lap_sec  <= sec_in;
        lap_msec <= msec_in;
      end
    end
  end

  assign enable = (state_q == RUN) || (state_q == LAP);
  assign state  = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// tb/tb_stop_watch_ctrl.sv - directed vector bench for stop_watch_ctrl
module tb_stop_watch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lr = 1'b0;
  logic [6:0]  min_in = '0;
  logic [6:0]  sec_in = '0;
  logic [14:0] msec_in = '0;
  logic        enable, zero, lap_valid;
  logic [6:0]  lap_min, lap_sec;
  logic [14:0] lap_msec;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int zc;

  stop_watch_ctrl #(.DEBOUNCE_CYCLES(20), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .min_in(min_in), .sec_in(sec_in), .msec_in(msec_in),
    .enable(enable), .zero(zero), .lap_valid(lap_valid),
    .lap_min(lap_min), .lap_sec(lap_sec), .lap_msec(lap_msec), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss, lr;
    logic [6:0]  mi, se;
    logic [14:0] ms;
    int          st, en, lv, lmi, lse, lms, zcount;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Hold the buttons long enough for one accepted press, then release and settle.
  task automatic press(input logic ss, input logic lr);
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    zc = 0;
    repeat (30) begin @(negedge clk); zc += int'(zero); end
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (30) begin @(negedge clk); zc += int'(zero); end
  endtask

  task automatic chk_all(input string tag, input int st, input int en, input int lv,
                         input int lmi, input int lse, input int lms);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_enable"}, int'(enable), en);
    chk({tag, "_lap_valid"}, int'(lap_valid), lv);
    chk({tag, "_lap_min"}, int'(lap_min), lmi);
    chk({tag, "_lap_sec"}, int'(lap_sec), lse);
    chk({tag, "_lap_msec"}, int'(lap_msec), lms);
  endtask

  initial begin
    int trans;
    logic [1:0] prev;

    //          ss    lr    min sec msec  st en lv lmi lse lms  zero
    vecs[0]  = '{1'b0, 1'b1, 0,  0,  0,   0, 0, 0, 0,  0,  0,   1};
    vecs[1]  = '{1'b1, 1'b0, 0,  0,  0,   1, 1, 0, 0,  0,  0,   0};
    vecs[2]  = '{1'b0, 1'b1, 2,  15, 437, 3, 1, 1, 2,  15, 437, 0};
    vecs[3]  = '{1'b0, 1'b1, 9,  9,  9,   1, 1, 0, 2,  15, 437, 0};
    vecs[4]  = '{1'b1, 1'b0, 0,  0,  0,   2, 0, 0, 2,  15, 437, 0};
    vecs[5]  = '{1'b1, 1'b0, 0,  0,  0,   1, 1, 0, 2,  15, 437, 0};
    vecs[6]  = '{1'b0, 1'b1, 5,  6,  7,   3, 1, 1, 5,  6,  7,   0};
    vecs[7]  = '{1'b1, 1'b0, 1,  1,  1,   2, 0, 0, 5,  6,  7,   0};
    vecs[8]  = '{1'b0, 1'b1, 0,  0,  0,   0, 0, 0, 0,  0,  0,   1};
    vecs[9]  = '{1'b1, 1'b0, 0,  0,  0,   1, 1, 0, 0,  0,  0,   0};
    vecs[10] = '{1'b1, 1'b1, 1,  2,  3,   2, 0, 0, 0,  0,  0,   0};
    vecs[11] = '{1'b0, 1'b1, 0,  0,  0,   0, 0, 0, 0,  0,  0,   1};

    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_zero", int'(zero), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", int'(state), 0);

    for (int i = 0; i < 12; i++) begin
      min_in  = vecs[i].mi;
      sec_in  = vecs[i].se;
      msec_in = vecs[i].ms;
      press(vecs[i].ss, vecs[i].lr);
      min_in  = 7'd99;
      sec_in  = 7'd99;
      msec_in = 15'd9999;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].lv,
              vecs[i].lmi, vecs[i].lse, vecs[i].lms);
      chk($sformatf("vec%0d_zero_cycles", i), zc, vecs[i].zcount);
    end

    // Bounce rejection followed by exact 23-edge press latency.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk); btn_ss = 1'b1;
      repeat (18) @(negedge clk);
      btn_ss = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("bounce_state", int'(state), 0);
    btn_ss = 1'b1;
    repeat (22) @(posedge clk);
    @(negedge clk);
    chk("latency_edge22_state", int'(state), 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_edge23_state", int'(state), 1);
    chk("latency_edge23_enable", int'(enable), 1);
    repeat (17) @(negedge clk);
    btn_ss = 1'b0;
    repeat (30) @(negedge clk);
    chk("bounce_run_hold", int'(state), 1);

    // Asynchronous reset while in LAP with a nonzero snapshot.
    min_in = 7'd3; sec_in = 7'd4; msec_in = 15'd5;
    press(1'b0, 1'b1);
    chk("pre_reset_lap_sec", int'(lap_sec), 4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);

    // Button held across reset release counts as a fresh press.
    btn_ss = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (22) @(posedge clk);
    @(negedge clk);
    chk("held_reset_edge22", int'(state), 0);
    @(posedge clk);
    @(negedge clk);
    chk("held_reset_edge23", int'(state), 1);
    btn_ss = 1'b0;
    repeat (30) @(negedge clk);

    // Reset in the middle of a debounce leaves nothing pending.
    press(1'b1, 1'b0);
    chk("to_stop", int'(state), 2);
    @(negedge clk); btn_ss = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    btn_ss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_debounce_reset", int'(state), 0);

    // Long hold yields exactly one transition.
    @(negedge clk); btn_ss = 1'b1;
    trans = 0;
    prev = state;
    repeat (500) begin
      @(negedge clk);
      if (state != prev) trans++;
      prev = state;
    end
    btn_ss = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (state != prev) trans++;
      prev = state;
    end
    chk("hold_transitions", trans, 1);
    chk("hold_state", int'(state), 1);
    press(1'b1, 1'b0);
    chk("hold_then_press", int'(state), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stop_watch_ctrl.md
# stop_watch_ctrl

Front-panel controller that sits directly upstream of the stopwatch counter. It takes two raw push-buttons (start/stop and lap/reset), synchronizes and debounces them, and runs a four-state FSM. The FSM drives the counter's `enable` level and one-cycle `zero` pulse. It also latches lap snapshots of the counter's live `min`/`sec`/`msec` outputs for the display path.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 20: number of consecutive cycles a synchronized button level must be stable before it is accepted. Legal range is 2 or more. At a 1 kHz clk this is 20 ms.
- `CNT_W`, default 5: width of each debounce counter. It must hold `DEBOUNCE_CYCLES-1`.

**Ports**
- `clk`, in, 1: system clock, the same clock as the counter (1 ms tick).
- `rst`, in, 1: asynchronous, active-low reset.
- `btn_ss`, in, 1: raw start/stop button, active high, asynchronous to clk.
- `btn_lr`, in, 1: raw lap/reset button, active high, asynchronous to clk.
- `min_in`, in, 7: live minutes from the counter.
- `sec_in`, in, 7: live seconds from the counter.
- `msec_in`, in, 15: live milliseconds from the counter.
- `enable`, out, 1: count enable to the counter.
- `zero`, out, 1: clear pulse to the counter, exactly one cycle wide.
- `lap_valid`, out, 1: high while the display shows the frozen lap value.
- `lap_min`, out, 7: latched lap minutes.
- `lap_sec`, out, 7: latched lap seconds.
- `lap_msec`, out, 15: latched lap milliseconds.
- `state`, out, 2: FSM state, for debug and LEDs.

## Operation

**Input conditioning (per button)**
- Each button passes through a 2-FF synchronizer giving `s2`.
- Debounce:
  - If `s2 != db`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with `s2` still different, `db <= s2` and the counter clears.
  - If `s2 == db`, the counter clears.
- Press pulse = `db & ~db_d`, where `db_d` is `db` delayed one cycle. It is high for exactly one cycle per accepted press.
- Release is debounced the same way. A held button yields one press only.
- Bounces shorter than `DEBOUNCE_CYCLES` cycles produce no press.

**FSM (state encoding)**

IDLE = 0, RUN = 1, STOP = 2, LAP = 3.
- **IDLE:**
  - `ss` press goes to RUN.
  - `lr` press pulses `zero` and stays in IDLE.
- **RUN:**
  - `ss` press goes to STOP.
  - `lr` press latches `lap_*` from `*_in` at that edge, sets `lap_valid`, and goes to LAP.
- **LAP** (counter keeps running):
  - `lr` press clears `lap_valid` and goes to RUN.
  - `ss` press clears `lap_valid` and goes to STOP.
- **STOP:**
  - `ss` press goes to RUN, resuming without a clear.
  - `lr` press pulses `zero`, clears `lap_*` to 0, and goes to IDLE.

**Output decode and priority**
- `enable` = 1 in RUN and LAP, 0 otherwise. It is a combinational decode of the state register.
- If `ss` and `lr` presses occur in the same cycle, `ss` wins and `lr` is discarded, not queued.
- `lap_*` hold their value outside lap captures. They are overwritten only on a RUN-to-LAP capture or cleared on a STOP-to-IDLE transition.

## Timing

**Reset values** (asynchronous, immediate on `rst`=0)
- `state` = IDLE, `enable` = 0, `zero` = 0, `lap_valid` = 0, `lap_min` = `lap_sec` = `lap_msec` = 0.
- All synchronizer flops, `db`, `db_d` and debounce counters = 0.

**Press latency**
- The raw button is sampled high at edge E0. `db` rises at edge E(N+1), where N = `DEBOUNCE_CYCLES`.
- The press pulse is high during the following cycle, and the state register updates at E(N+2): N+3 edges after first sampling.
- With N=20, `state` and `enable` change at the 23rd edge.

**Output timing**
- `zero` is registered. It is high for the single cycle after the transition edge that generates it, so the counter clears on the next edge.
- Lap capture uses the `*_in` values present in the cycle the press pulse is high, sampled at the transition edge. There is zero additional latency.

**Boundary cases**
- Reset asserted mid-press or mid-debounce: all progress is lost. Nothing is pending after release.
- Button held through reset release: it is treated as a fresh press after N+3 edges, which is required behaviour.
- Repeated lap presses: only RUN-to-LAP captures. A LAP-to-RUN press never alters `lap_*`.

## Test plan

1. **Reset defaults:** assert `rst`=0 mid-run → all outputs 0 immediately, `state`=0. Release → state stays IDLE with no buttons pressed.
2. **Bounce rejection:** N=20; toggle `btn_ss` high for 19 cycles, low for 3, repeatedly → no state change. Then hold 40 cycles → `enable`=1 exactly at edge 23 after the final rise, `state`=1.
3. **Full cycle:** `ss` press → RUN. `ss` press → STOP (`enable` 0). `lr` press → `zero` high exactly 1 cycle, `state`=0.
4. **Lap capture:** in RUN, drive `min_in`=2, `sec_in`=15, `msec_in`=437 during the press cycle → `lap_*`=2/15/437 and `lap_valid`=1, `state`=3. The next `lr` press → `lap_valid`=0, `state`=1, `lap_*` unchanged.
5. **Simultaneous press:** both raw buttons rise on the same edge in RUN → STOP only, no lap capture, `lap_valid` stays 0.
6. **Hold without repeat:** hold `btn_ss` for 500 cycles in IDLE → exactly one transition to RUN. Release, then press again → STOP.
